// File: rtl/preamble_capture_ctrl_pkg.sv
// Shared definitions for preamble_capture_ctrl: FSM state encoding,
// settings-bus register offsets and register reset defaults.
package preamble_capture_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  localparam logic [7:0] SR_ENABLE      = 8'd0;
  localparam logic [7:0] SR_CAPTURE_LEN = 8'd1;
  localparam logic [7:0] SR_HOLDOFF_LEN = 8'd2;

  localparam int unsigned CAPTURE_LEN_RST = 64;
  localparam int unsigned HOLDOFF_LEN_RST = 0;

endpackage

// File: rtl/preamble_capture_ctrl_fifo_flop.sv
// axi_fifo_flop: single-entry registered AXI-Stream stage. Accepts a new beat
// whenever empty or draining in the same cycle, so it runs at full rate.
module preamble_capture_ctrl_fifo_flop #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tvalid,
  input  logic             o_tready
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  assign i_tready = ~r_valid | o_tready;
  assign o_tdata  = r_data;
  assign o_tvalid = r_valid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_tready) begin
      r_valid <= i_tvalid;
      if (i_tvalid) r_data <= i_tdata;
    end
  end

endmodule

// File: rtl/preamble_capture_ctrl.sv
// Burst capture sequencer behind the short-preamble detector: arms on a peak
// beat, emits the peak phase once, forwards a framed burst, then holds off.
// Optional statistics counters: define PREAMBLE_CAPTURE_CTRL_STATS_EN.
module preamble_capture_ctrl
  import preamble_capture_ctrl_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SR_BASE = 0,
  parameter int LEN_W   = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [WIDTH-1:0] i_samples_tdata,
  input  logic             i_samples_tlast,
  input  logic             i_samples_tvalid,
  output logic             i_samples_tready,
  input  logic [15:0]      i_phase_tdata,
  input  logic             i_phase_tlast,
  input  logic             i_phase_tvalid,
  output logic             i_phase_tready,
  output logic [WIDTH-1:0] o_samples_tdata,
  output logic             o_samples_tlast,
  output logic             o_samples_tvalid,
  input  logic             o_samples_tready,
  output logic [15:0]      o_phase_tdata,
  output logic             o_phase_tvalid,
  input  logic             o_phase_tready,
  output logic [1:0]       o_state,
  output logic [31:0]      o_burst_count,
  output logic [31:0]      o_miss_count
);

  localparam logic [7:0] A_ENABLE      = 8'(SR_BASE + int'(SR_ENABLE));
  localparam logic [7:0] A_CAPTURE_LEN = 8'(SR_BASE + int'(SR_CAPTURE_LEN));
  localparam logic [7:0] A_HOLDOFF_LEN = 8'(SR_BASE + int'(SR_HOLDOFF_LEN));

  state_t           r_state, w_next;
  logic             r_enable;
  logic [LEN_W-1:0] r_capture_len, r_holdoff_len;
  logic [LEN_W-1:0] r_cnt, r_hold_snap;
  logic [15:0]      r_phase;
  logic             r_phase_valid;

  logic w_accept, w_xfer, w_phase_full, w_cnt_last;
  logic w_load, w_push, w_skid_ready;
  logic w_unused;

  // A beat moves only when both streams offer it; reset holds both readies low.
  assign w_accept     = (r_state == ST_CAPTURE) ? w_skid_ready : 1'b1;
  assign w_xfer       = i_samples_tvalid & i_phase_tvalid & w_accept & resetn;
  assign i_samples_tready = w_xfer;
  assign i_phase_tready   = w_xfer;
  assign w_phase_full = r_phase_valid & ~o_phase_tready;
  assign w_cnt_last   = (r_cnt == LEN_W'(1));
  assign w_unused     = ^{i_samples_tlast, set_data};

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_push = 1'b0;
    case (r_state)
      ST_IDLE: if (r_enable) w_next = ST_SEARCH;
      ST_SEARCH: begin
        if (!r_enable) w_next = ST_IDLE;
        else if (w_xfer && i_phase_tlast && !w_phase_full) begin
          w_load = 1'b1;
          w_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        w_push = w_xfer;
        if (w_xfer && w_cnt_last) begin
          if (r_hold_snap != '0) w_next = ST_HOLDOFF;
          else                   w_next = r_enable ? ST_SEARCH : ST_IDLE;
        end
      end
      ST_HOLDOFF: begin
        if (!r_enable)                w_next = ST_IDLE;
        else if (w_xfer && w_cnt_last) w_next = ST_SEARCH;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= ST_IDLE;
      r_enable      <= 1'b0;
      r_capture_len <= LEN_W'(CAPTURE_LEN_RST);
      r_holdoff_len <= LEN_W'(HOLDOFF_LEN_RST);
      r_cnt         <= '0;
      r_hold_snap   <= '0;
      r_phase       <= '0;
      r_phase_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (set_stb) begin
        if (set_addr == A_ENABLE)      r_enable      <= set_data[0];
        if (set_addr == A_CAPTURE_LEN) r_capture_len <= set_data[LEN_W-1:0];
        if (set_addr == A_HOLDOFF_LEN) r_holdoff_len <= set_data[LEN_W-1:0];
      end
      if (r_phase_valid && o_phase_tready) r_phase_valid <= 1'b0;
      // Lengths are snapshotted at the peak so mid-burst writes only affect the next burst.
      if (w_load) begin
        r_phase       <= i_phase_tdata;
        r_phase_valid <= 1'b1;
        r_cnt         <= (r_capture_len == '0) ? LEN_W'(1) : r_capture_len;
        r_hold_snap   <= r_holdoff_len;
      end else if (w_xfer && (r_state == ST_CAPTURE)) begin
        r_cnt <= w_cnt_last ? r_hold_snap : r_cnt - LEN_W'(1);
      end else if (w_xfer && (r_state == ST_HOLDOFF)) begin
        r_cnt <= r_cnt - LEN_W'(1);
      end
    end
  end

  preamble_capture_ctrl_fifo_flop #(.WIDTH(WIDTH + 1)) u_skid (
    .clk      (clk),
    .resetn   (resetn),
    .i_tdata  ({w_cnt_last, i_samples_tdata}),
    .i_tvalid (w_push),
    .i_tready (w_skid_ready),
    .o_tdata  ({o_samples_tlast, o_samples_tdata}),
    .o_tvalid (o_samples_tvalid),
    .o_tready (o_samples_tready)
  );

  assign o_phase_tdata  = r_phase;
  assign o_phase_tvalid = r_phase_valid;
  assign o_state        = r_state;

`ifdef PREAMBLE_CAPTURE_CTRL_STATS_EN
  logic [31:0] r_burst_count, r_miss_count;
  logic        w_drop;

  assign w_drop = (r_state == ST_SEARCH) & r_enable & w_xfer & i_phase_tlast & w_phase_full;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_burst_count <= '0;
      r_miss_count  <= '0;
    end else begin
      if (w_load) r_burst_count <= r_burst_count + 32'd1;
      if (w_drop) r_miss_count  <= r_miss_count + 32'd1;
    end
  end

  assign o_burst_count = r_burst_count;
  assign o_miss_count  = r_miss_count;
`else
  assign o_burst_count = '0;
  assign o_miss_count  = '0;
`endif

endmodule
